// File: rtl/crc_ccitt_pkg.sv
// crc_ccitt_pkg
// Shared CRC-CCITT definitions for the checker and the generator:
//   - polynomial and the two common preset values
//   - checker FSM state encoding
//   - crc_ccitt_byte(): fold one byte into a running CRC, MSB first,
//     non-reflected, no final XOR.
package crc_ccitt_pkg;

  localparam logic [15:0] CRC_CCITT_POLY        = 16'h1021;
  localparam logic [15:0] CRC_CCITT_INIT_XMODEM = 16'h0000;
  localparam logic [15:0] CRC_CCITT_INIT_FALSE  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESULT = 2'd2
  } crc_chk_state_e;

  function automatic logic [15:0] crc_ccitt_byte(input logic [15:0] crc,
                                                 input logic [7:0]  data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_CCITT_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_ccitt_checker_if.sv
// crc_ccitt_checker_if
// Byte-stream input and per-frame result bundle of the CRC checker.
//   in_valid/in_ready/in_data/in_sof/in_eof : framed byte stream
//   res_valid : one-cycle result pulse; res_ok, res_len_err, res_crc,
//   res_rx_crc, res_len : result fields, held until the next result
// master = upstream deframer / result consumer, slave = checker.
interface crc_ccitt_checker_if #(
  parameter int LEN_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_sof;
  logic             in_eof;
  logic             res_valid;
  logic             res_ok;
  logic             res_len_err;
  logic [15:0]      res_crc;
  logic [15:0]      res_rx_crc;
  logic [LEN_W-1:0] res_len;

  modport master (
    output in_valid, in_data, in_sof, in_eof,
    input  in_ready,
    input  res_valid, res_ok, res_len_err, res_crc, res_rx_crc, res_len
  );

  modport slave (
    input  in_valid, in_data, in_sof, in_eof,
    output in_ready,
    output res_valid, res_ok, res_len_err, res_crc, res_rx_crc, res_len
  );
endinterface

// File: rtl/crc_ccitt_byte_step.sv
// crc_ccitt_byte_step
// Combinational fold of one byte into a 16-bit CRC: 8 serial steps,
// MSB first, fb = crc[15]^bit; crc = (crc<<1) ^ (fb ? POLY : 0).
//   crc_i  : running CRC
//   data_i : byte to fold
//   crc_o  : updated CRC
module crc_ccitt_byte_step
  import crc_ccitt_pkg::*;
#(
  parameter logic [15:0] POLY = CRC_CCITT_POLY
) (
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] c;
  logic        fb;

  always_comb begin
    c  = crc_i;
    fb = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data_i[i];
      c  = {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
  end

  assign crc_o = c;

endmodule

// File: rtl/crc_ccitt_checker.sv
// crc_ccitt_checker
// Receive-side CRC-CCITT checker. Takes a framed byte stream whose last
// two bytes are the transmitted CRC (MSB first), computes the CRC over
// the payload and emits one result per frame, the cycle after eof.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus (slave modport)   : byte stream in, result out
//   stat_clr, stat_good, stat_bad : good/bad frame counters, only when
//                           CRC_CHK_STATS_EN is defined
// A 2-byte hold register delays folding so that, at eof, crc covers the
// payload and hold holds the received CRC. An sof inside a frame aborts
// it (error result) and starts a new frame with that byte.
module crc_ccitt_checker
  import crc_ccitt_pkg::*;
#(
  parameter logic [15:0] POLY    = CRC_CCITT_POLY,
  parameter logic [15:0] INIT    = CRC_CCITT_INIT_XMODEM,
  parameter int          MAX_LEN = 1024,
  parameter int          LEN_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef CRC_CHK_STATS_EN
  input  logic                stat_clr,
  output logic [31:0]         stat_good,
  output logic [31:0]         stat_bad,
`endif
  crc_ccitt_checker_if.slave  bus
);

  crc_chk_state_e   state_q;
  logic [15:0]      crc_q, hold_q;
  logic [LEN_W-1:0] cnt_q;
  logic             rdy_q;
  logic             ret_run_q;  // abort result done -> resume new frame
  logic             pend_q;     // abort byte also carried eof: 2nd result

  logic             res_valid_q, res_ok_q, res_len_err_q;
  logic [15:0]      res_crc_q, res_rx_q;
  logic [LEN_W-1:0] res_len_q;

  logic             xfer;
  logic [15:0]      step_crc, crc_fold, hold_sh;
  logic [LEN_W-1:0] cnt_inc;

  assign xfer    = bus.in_valid && rdy_q;
  assign hold_sh = {hold_q[7:0], bus.in_data};
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);

  crc_ccitt_byte_step #(.POLY(POLY)) u_step (
    .crc_i  (crc_q),
    .data_i (hold_q[15:8]),
    .crc_o  (step_crc)
  );

  // The byte leaving hold is a real payload byte only once two bytes sit
  // in hold; before that the upper half is still the zero preset.
  assign crc_fold = (cnt_q >= LEN_W'(2)) ? step_crc : crc_q;

  // Result source selection: normal eof uses the post-update frame state,
  // an abort reports the old frame as it stood, and the pending case
  // reports the single-byte frame already loaded.
  logic             emit, e_abort, e_len_err, e_ok;
  logic [15:0]      e_crc, e_hold;
  logic [LEN_W-1:0] e_cnt;

  always_comb begin
    emit    = 1'b0;
    e_abort = 1'b0;
    e_crc   = crc_fold;
    e_hold  = hold_sh;
    e_cnt   = cnt_inc;
    case (state_q)
      IDLE: begin
        if (xfer && bus.in_sof && bus.in_eof) begin
          emit   = 1'b1;
          e_crc  = INIT;
          e_hold = {8'h00, bus.in_data};
          e_cnt  = LEN_W'(1);
        end
      end
      RUN: begin
        if (xfer && bus.in_sof) begin
          emit    = 1'b1;
          e_abort = 1'b1;
          e_crc   = crc_q;
          e_hold  = hold_q;
          e_cnt   = cnt_q;
        end else if (xfer && bus.in_eof) begin
          emit = 1'b1;
        end
      end
      RESULT: begin
        if (pend_q) begin
          emit   = 1'b1;
          e_crc  = crc_q;
          e_hold = hold_q;
          e_cnt  = cnt_q;
        end
      end
      default: ;
    endcase
    e_len_err = (e_cnt < LEN_W'(3)) || (e_cnt > LEN_W'(MAX_LEN)) || e_abort;
    e_ok      = !e_len_err && (e_crc == e_hold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      crc_q         <= '0;
      hold_q        <= '0;
      cnt_q         <= '0;
      rdy_q         <= 1'b0;
      ret_run_q     <= 1'b0;
      pend_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_ok_q      <= 1'b0;
      res_len_err_q <= 1'b0;
      res_crc_q     <= '0;
      res_rx_q      <= '0;
      res_len_q     <= '0;
    end else begin
      res_valid_q <= emit;
      if (emit) begin
        res_ok_q      <= e_ok;
        res_len_err_q <= e_len_err;
        res_crc_q     <= e_crc;
        res_rx_q      <= e_hold;
        res_len_q     <= e_cnt;
      end

      case (state_q)
        IDLE: begin
          rdy_q     <= 1'b1;
          ret_run_q <= 1'b0;
          pend_q    <= 1'b0;
          if (xfer && bus.in_sof) begin
            crc_q  <= INIT;
            hold_q <= {8'h00, bus.in_data};
            cnt_q  <= LEN_W'(1);
            if (bus.in_eof) begin
              state_q <= RESULT;
              rdy_q   <= 1'b0;
            end else begin
              state_q <= RUN;
            end
          end
        end

        RUN: begin
          if (xfer) begin
            if (bus.in_sof) begin
              crc_q     <= INIT;
              hold_q    <= {8'h00, bus.in_data};
              cnt_q     <= LEN_W'(1);
              state_q   <= RESULT;
              rdy_q     <= 1'b0;
              ret_run_q <= !bus.in_eof;
              pend_q    <= bus.in_eof;
            end else begin
              crc_q  <= crc_fold;
              hold_q <= hold_sh;
              cnt_q  <= cnt_inc;
              if (bus.in_eof) begin
                state_q   <= RESULT;
                rdy_q     <= 1'b0;
                ret_run_q <= 1'b0;
              end
            end
          end
        end

        RESULT: begin
          if (pend_q) begin
            pend_q <= 1'b0;
          end else begin
            state_q   <= ret_run_q ? RUN : IDLE;
            rdy_q     <= 1'b1;
            ret_run_q <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_ok      = res_ok_q;
  assign bus.res_len_err = res_len_err_q;
  assign bus.res_crc     = res_crc_q;
  assign bus.res_rx_crc  = res_rx_q;
  assign bus.res_len     = res_len_q;

`ifdef CRC_CHK_STATS_EN
  logic [31:0] good_q, bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q <= '0;
      bad_q  <= '0;
    end else if (stat_clr) begin
      good_q <= '0;
      bad_q  <= '0;
    end else if (res_valid_q) begin
      if (res_ok_q) begin
        if (!(&good_q)) good_q <= good_q + 32'd1;
      end else begin
        if (!(&bad_q)) bad_q <= bad_q + 32'd1;
      end
    end
  end

  assign stat_good = good_q;
  assign stat_bad  = bad_q;
`endif

endmodule

// File: doc/crc_ccitt_checker.md
Name: crc_ccitt_checker

Overview:
- Receive-side counterpart of the team's CRC-CCITT generator.
- Consumes a framed byte stream whose last two bytes are the transmitted CRC, MSB first.
- Computes CRC-CCITT over the payload bytes, compares it with the received CRC, and reports one result per frame.
- Sits between the byte deframer and the packet buffer.

Parameters:
- POLY, 16'h1021, generator polynomial (x^16+x^12+x^5+1), MSB-first, non-reflected.
- INIT, 16'h0000, CRC preset loaded at start of frame. No final XOR.
- MAX_LEN, 1024, maximum total frame bytes, payload plus 2 CRC bytes.
- LEN_W, 16, width of the byte counter and the res_len output.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte strobe.
- in_ready  out  1  checker can accept a byte.
- in_data  in  8  frame byte.
- in_sof  in  1  first byte of frame; qualified by in_valid.
- in_eof  in  1  last byte of frame; qualified by in_valid.
- res_valid  out  1  one-cycle result pulse.
- res_ok  out  1  CRC matched and length legal.
- res_len_err  out  1  frame shorter than 3 or longer than MAX_LEN bytes, or aborted.
- res_crc  out  16  CRC computed over the payload.
- res_rx_crc  out  16  last two frame bytes, {second-last, last}.
- res_len  out  LEN_W  total bytes accepted in the frame, saturating.

Behaviour:
- Reset:
  - Asynchronous, rst_n low.
  - State goes to IDLE.
  - All res_* outputs are 0.
  - in_ready is 0 while rst_n is low and 1 from the first clock edge after release.
  - Reset mid-frame discards the frame and produces no result.
- Transfer rule: a byte is transferred when in_valid && in_ready.
- IDLE:
  - A transfer without in_sof is discarded; no state change.
  - A transfer with in_sof loads crc=INIT, loads hold={8'h00,in_data}, sets cnt=1 and goes to RUN.
  - If in_eof is also set, go directly to RESULT instead.
- RUN, on each transfer:
  - 2-byte hold shift register: the byte leaving hold[15:8] is folded into crc, but only when cnt>=2.
  - Fold is 8 serial steps MSB-first within one cycle: fb=crc[15]^bit; crc=(crc<<1)^(fb?POLY:0).
  - Then hold={hold[7:0],in_data} and cnt increments, saturating at all-ones.
  - Result: after a frame of N bytes, crc covers bytes 0..N-3 and hold holds the CRC bytes.
  - in_eof on a transfer goes to RESULT.
  - in_sof on a transfer in RUN is an abort:
    - Emit a result in the next cycle with res_len_err=1 and res_ok=0.
    - The new byte is not lost; it is captured as the first byte of the new frame, with the same load as IDLE.
    - After the result, return to RUN.
- RESULT, exactly one cycle:
  - in_ready=0, res_valid=1.
  - res_crc=crc, res_rx_crc=hold, res_len=cnt.
  - res_len_err = (cnt<3) || (cnt>MAX_LEN) || abort.
  - res_ok = !res_len_err && (crc==hold).
  - Next state is IDLE, or RUN after an abort.
  - res_* hold their values until the next result; only res_valid pulses.
- Latency: the result appears the cycle after the eof transfer.
- Throughput: maximum one frame per N+1 cycles.
- in_valid is ignored while in_ready=0. The upstream block must hold the byte until in_ready returns.

Optional Feature:
- Macro: CRC_CHK_STATS_EN.
- Defined:
  - Adds outputs stat_good[31:0] and stat_bad[31:0].
  - stat_good increments on each res_valid with res_ok=1; stat_bad increments on each res_valid with res_ok=0.
  - Both counters saturate at 32'hFFFFFFFF.
  - Input stat_clr (1 bit, synchronous) zeroes both counters. Clear wins over a simultaneous increment.
  - Both counters reset to 0.
- Undefined: ports absent, no counter logic.

Decomposition:
- Package crc_ccitt_pkg:
  - CRC_CCITT_POLY=16'h1021 and CRC_CCITT_INIT_XMODEM=16'h0000, CRC_CCITT_INIT_FALSE=16'hFFFF.
  - State enum {IDLE,RUN,RESULT}.
  - Function crc_ccitt_byte(crc,data), shared with the generator.
- Sub-module crc_ccitt_byte_step: combinational 8-bit fold, reused by the generator rewrite.

Test Plan:
- INIT=0. Frame "123456789" + 8'h31,8'hC3 (11 bytes) -> res_valid one cycle after eof; res_ok=1, res_crc=16'h31C3, res_len=11.
- INIT=16'hFFFF. Same payload + 8'h29,8'hB1 -> res_ok=1, res_crc=16'h29B1. Flip one payload bit -> res_ok=0, res_len_err=0.
- INIT=0. Frame 8'h01,8'h10,8'h21 -> res_ok=1. Frame of 2 bytes -> res_len_err=1, res_ok=0. Single sof+eof byte -> res_len_err=1, res_len=1.
- sof after 5 bytes of a frame, then a valid 11-byte frame -> first result res_len_err=1, res_len=5; second result res_ok=1 with no byte lost.
- in_valid held high continuously across back-to-back frames -> in_ready low exactly on RESULT cycles. rst_n pulsed mid-frame -> no result; the next frame checks correctly.
- With CRC_CHK_STATS_EN: 3 good frames and 2 bad -> stat_good=3, stat_bad=2. stat_clr coincident with a result -> both counters 0.
